// File: rtl/pc_branch_unit.sv
// ============================================================================
// pc_branch_unit : NZCV flags, condition evaluation, next-PC select, branch stats
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_branch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                OFF_W    = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic [3:0]        NZCVWRITE,
    input  logic [3:0]        ALU_NZCV,
    input  logic [3:0]        COND,
    input  logic              C_BRANCH,
    input  logic              R_BRANCH,
    input  logic [OFF_W-1:0]  BR_OFFSET,
    input  logic [ADDR_W-1:0] RB_TARGET,
    output logic [ADDR_W-1:0] PC,
    output logic [3:0]        NZCV,
    output logic              TAKEN,
    output logic [CNT_W-1:0]  BR_CNT,
    output logic [CNT_W-1:0]  TAKEN_CNT
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;

    logic              w_n, w_z, w_c, w_v;
    logic              w_cond_true;
    logic              w_is_branch;
    logic [ADDR_W-1:0] w_offset;

    assign {w_n, w_z, w_c, w_v} = nzcv_q;

    // Conditions only ever see the registered flags; same-cycle ALU flags are not forwarded.
    always_comb begin
        w_cond_true = 1'b0;
        case (COND)
            4'd0:    w_cond_true = w_z;
            4'd1:    w_cond_true = !w_z;
            4'd2:    w_cond_true = w_c;
            4'd3:    w_cond_true = !w_c;
            4'd4:    w_cond_true = w_n;
            4'd5:    w_cond_true = !w_n;
            4'd6:    w_cond_true = w_v;
            4'd7:    w_cond_true = !w_v;
            4'd8:    w_cond_true = w_c && !w_z;
            4'd9:    w_cond_true = !w_c || w_z;
            4'd10:   w_cond_true = (w_n == w_v);
            4'd11:   w_cond_true = (w_n != w_v);
            4'd12:   w_cond_true = !w_z && (w_n == w_v);
            4'd13:   w_cond_true = w_z || (w_n != w_v);
            4'd14:   w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_offset    = {{(ADDR_W-OFF_W){BR_OFFSET[OFF_W-1]}}, BR_OFFSET} << 2;
    assign w_is_branch = C_BRANCH || R_BRANCH;

    always_comb begin
        pc_d     = pc_q + ADDR_W'(4);
        taken_d  = 1'b0;
        if (R_BRANCH) begin
            pc_d    = {RB_TARGET[ADDR_W-1:1], 1'b0};
            taken_d = 1'b1;
        end else if (C_BRANCH && w_cond_true) begin
            pc_d    = pc_q + w_offset;
            taken_d = 1'b1;
        end

        nzcv_d = (nzcv_q & ~NZCVWRITE) | (ALU_NZCV & NZCVWRITE);

        br_cnt_d = br_cnt_q;
        if (w_is_branch && (br_cnt_q != {CNT_W{1'b1}}))
            br_cnt_d = br_cnt_q + CNT_W'(1);

        tk_cnt_d = tk_cnt_q;
        if (taken_d && (tk_cnt_q != {CNT_W{1'b1}}))
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            nzcv_q   <= 4'b0000;
            taken_q  <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else if (STALL) begin
            taken_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            nzcv_q   <= nzcv_d;
            taken_q  <= taken_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign PC        = pc_q;
    assign NZCV      = nzcv_q;
    assign TAKEN     = taken_q;
    assign BR_CNT    = br_cnt_q;
    assign TAKEN_CNT = tk_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// ============================================================================
// tb_pc_branch_unit : directed + random check of pc_branch_unit against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, c_br, r_br;
    logic [3:0]  wr, alu, cc;
    logic [23:0] off;
    logic [31:0] tgt;

    logic [31:0] pc;
    logic [3:0]  nzcv;
    logic        taken;
    logic [15:0] br_cnt, tk_cnt;
    logic [31:0] pc_s;
    logic [3:0]  nzcv_s;
    logic        taken_s;
    logic [1:0]  br_cnt_s, tk_cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_pc;
    bit          m_n, m_z, m_c, m_v;
    bit          m_taken;
    int          m_br, m_tk;

    always #5 clk = ~clk;

    pc_branch_unit #(.ADDR_W(32), .OFF_W(24), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .STALL(stall), .NZCVWRITE(wr), .ALU_NZCV(alu),
        .COND(cc), .C_BRANCH(c_br), .R_BRANCH(r_br), .BR_OFFSET(off),
        .RB_TARGET(tgt), .PC(pc), .NZCV(nzcv), .TAKEN(taken),
        .BR_CNT(br_cnt), .TAKEN_CNT(tk_cnt)
    );

    pc_branch_unit #(.ADDR_W(32), .OFF_W(24), .RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .CLK(clk), .RST(rst), .STALL(stall), .NZCVWRITE(wr), .ALU_NZCV(alu),
        .COND(cc), .C_BRANCH(c_br), .R_BRANCH(r_br), .BR_OFFSET(off),
        .RB_TARGET(tgt), .PC(pc_s), .NZCV(nzcv_s), .TAKEN(taken_s),
        .BR_CNT(br_cnt_s), .TAKEN_CNT(tk_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c);
        case (c)
            4'd0:    return m_z;
            4'd1:    return !m_z;
            4'd2:    return m_c;
            4'd3:    return !m_c;
            4'd4:    return m_n;
            4'd5:    return !m_n;
            4'd6:    return m_v;
            4'd7:    return !m_v;
            4'd8:    return m_c && !m_z;
            4'd9:    return !m_c || m_z;
            4'd10:   return m_n == m_v;
            4'd11:   return m_n != m_v;
            4'd12:   return !m_z && (m_n == m_v);
            4'd13:   return m_z || (m_n != m_v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step();
        bit   tk;
        int   o;
        if (rst) begin
            m_pc = 32'h0; {m_n, m_z, m_c, m_v} = 4'b0; m_taken = 0; m_br = 0; m_tk = 0;
        end else if (stall) begin
            m_taken = 0;
        end else begin
            tk = r_br || (c_br && cond_holds(cc));
            o  = $signed(off);
            if (r_br)      m_pc = tgt & ~32'h1;
            else if (tk)   m_pc = m_pc + 32'(o * 4);
            else           m_pc = m_pc + 32'd4;
            if (c_br || r_br) m_br++;
            if (tk)           m_tk++;
            m_taken = tk;
            if (wr[3]) m_n = alu[3];
            if (wr[2]) m_z = alu[2];
            if (wr[1]) m_c = alu[1];
            if (wr[0]) m_v = alu[0];
        end
    endtask

    task automatic compare_all();
        chk("pc",        pc,              m_pc);
        chk("nzcv",      32'(nzcv),       32'({m_n, m_z, m_c, m_v}));
        chk("taken",     32'(taken),      32'(m_taken));
        chk("br_cnt",    32'(br_cnt),     32'(sat(m_br, 65535)));
        chk("tk_cnt",    32'(tk_cnt),     32'(sat(m_tk, 65535)));
        chk("sat_br",    32'(br_cnt_s),   32'(sat(m_br, 3)));
        chk("sat_tk",    32'(tk_cnt_s),   32'(sat(m_tk, 3)));
    endtask

    task automatic cyc(input bit i_rst, input bit i_stall, input logic [3:0] i_wr,
                       input logic [3:0] i_alu, input logic [3:0] i_cc, input bit i_cb,
                       input bit i_rb, input logic [23:0] i_off, input logic [31:0] i_tgt);
        rst = i_rst; stall = i_stall; wr = i_wr; alu = i_alu; cc = i_cc;
        c_br = i_cb; r_br = i_rb; off = i_off; tgt = i_tgt;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 4'h0, 4'hF, 0, 0, 24'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 4'h0, 4'h0, 4'hF, 0, 0, 24'h0, 32'h0);
    endtask

    initial begin
        rst = 1; stall = 0; wr = 0; alu = 0; cc = 4'hF; c_br = 0; r_br = 0; off = 0; tgt = 0;
        m_pc = 0; {m_n, m_z, m_c, m_v} = 4'b0; m_taken = 0; m_br = 0; m_tk = 0;
        @(negedge clk);

        // Reset then sequential fetch
        do_reset();
        chk("rst_pc", pc, 32'h0);
        idle(); idle(); idle();
        chk("seq_pc", pc, 32'hC);

        // Flag write then EQ taken
        cyc(0, 0, 4'b0100, 4'b0100, 4'hF, 0, 0, 24'h0, 32'h0);
        chk("pc_before_eq", pc, 32'h10);
        cyc(0, 0, 4'b0000, 4'b0000, 4'h0, 1, 0, 24'd3, 32'h0);
        chk("eq_pc", pc, 32'h1C);
        chk("eq_taken", 32'(taken), 32'h1);
        chk("eq_brcnt", 32'(br_cnt), 32'h1);
        chk("eq_tkcnt", 32'(tk_cnt), 32'h1);

        // Same sequence with NE: not taken
        do_reset(); idle(); idle(); idle();
        cyc(0, 0, 4'b0100, 4'b0100, 4'hF, 0, 0, 24'h0, 32'h0);
        cyc(0, 0, 4'b0000, 4'b0000, 4'h1, 1, 0, 24'd3, 32'h0);
        chk("ne_pc", pc, 32'h14);
        chk("ne_taken", 32'(taken), 32'h0);
        chk("ne_tkcnt", 32'(tk_cnt), 32'h0);

        // Same-cycle flag write is invisible to the branch
        cyc(0, 0, 4'b0100, 4'b0000, 4'hF, 0, 0, 24'h0, 32'h0);
        cyc(0, 0, 4'b0100, 4'b0100, 4'h0, 1, 0, 24'd8, 32'h0);
        chk("hazard_taken", 32'(taken), 32'h0);
        cyc(0, 0, 4'b0001, 4'b1111, 4'hF, 0, 0, 24'h0, 32'h0);
        chk("mask_nzcv", 32'(nzcv), 32'h5);

        // Register branch and priority over C_BRANCH
        cyc(0, 0, 4'h0, 4'h0, 4'hF, 0, 1, 24'h0, 32'h0000_0101);
        chk("rb_pc", pc, 32'h100);
        chk("rb_taken", 32'(taken), 32'h1);
        cyc(0, 0, 4'h0, 4'h0, 4'hF, 1, 1, 24'd5, 32'h0000_2003);
        chk("both_pc", pc, 32'h2002);

        // Negative offset wraps below zero
        do_reset(); idle(); idle();
        cyc(0, 0, 4'h0, 4'h0, 4'hE, 1, 0, 24'hFF_FFFC, 32'h0);
        chk("wrap_pc", pc, 32'hFFFF_FFF8);

        // GE with N=V=1, LT with N=1,V=0
        cyc(0, 0, 4'b1111, 4'b1001, 4'hF, 0, 0, 24'h0, 32'h0);
        cyc(0, 0, 4'h0, 4'h0, 4'hA, 1, 0, 24'd1, 32'h0);
        chk("ge_taken", 32'(taken), 32'h1);
        cyc(0, 0, 4'b0001, 4'b0000, 4'hF, 0, 0, 24'h0, 32'h0);
        cyc(0, 0, 4'h0, 4'h0, 4'hB, 1, 0, 24'd1, 32'h0);
        chk("lt_taken", 32'(taken), 32'h1);

        // Stall holds state
        cyc(0, 1, 4'b1111, 4'b1111, 4'hE, 1, 0, 24'd16, 32'h0);
        chk("stall_taken", 32'(taken), 32'h0);

        // Saturation of the narrow counters
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'h0, 4'h0, 4'hF, 0, 1, 24'h0, 32'h40 * i);
        chk("sat_br_cnt", 32'(br_cnt_s), 32'h3);
        chk("sat_tk_cnt", 32'(tk_cnt_s), 32'h3);
        chk("wide_br_cnt", 32'(br_cnt), 32'h5);

        // Reset wins over a register branch
        cyc(1, 0, 4'h0, 4'h0, 4'hF, 0, 1, 24'h0, 32'h1234);
        chk("rst_rb_pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                4'($urandom), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                24'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
